ct_butterfly_pipe: RTL and testbench

//  Pipelined Cooley-Tukey NTT butterfly for ML-KEM coefficients (mod Q):
//  out_a = (a + b*w) mod Q, out_b = (a - b*w) mod Q.

---
 rtl/ct_butterfly_pipe.sv | 137 +++++++++++++
 tb/tb_ct_butterfly_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ct_butterfly_pipe
// Description : Pipelined Cooley-Tukey NTT butterfly mod Q with a Barrett
//               multiplier and a whole-pipe stall. Optional feature macro:
//               BUTTERFLY_HALVE_EN (adds half_i, scales results by 2^-1 mod Q).
// Revision    : 1.0 - initial release
// ============================================================================
module ct_butterfly_pipe #(
    parameter int DWIDTH = 12,
    parameter int Q      = 3329
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    input  logic [DWIDTH-1:0] w_i,
`ifdef BUTTERFLY_HALVE_EN
    input  logic              half_i,
`endif
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_a_o,
    output logic [DWIDTH-1:0] out_b_o
);

    localparam int K  = 2 * DWIDTH;
    localparam int MW = DWIDTH + 1;
    localparam int PW = K + MW;
    localparam logic [MW-1:0]     M     = MW'((64'd1 << K) / 64'(Q));
    localparam logic [DWIDTH:0]   c_q_s = (DWIDTH+1)'(Q);
    localparam logic [DWIDTH+1:0] c_q_r = (DWIDTH+2)'(Q);
    localparam logic [K-1:0]      c_q_p = K'(Q);

    logic              r_v1, r_v2, r_v3;
    logic [DWIDTH-1:0] r_a1, r_a2, r_a3;
    logic [K-1:0]      r_p1, r_p2;
    logic [MW-1:0]     r_qh2;
    logic [DWIDTH-1:0] r_t3;
    logic              r_out_valid;
    logic [DWIDTH-1:0] r_out_a, r_out_b;
`ifdef BUTTERFLY_HALVE_EN
    logic              r_h1, r_h2, r_h3;
`endif

    logic              w_adv;
    logic [PW-1:0]     w_prod;
    logic [MW-1:0]     w_qh;
    logic [K-1:0]      w_r_full;
    logic [DWIDTH+1:0] w_r, w_r1, w_t_full;
    logic [DWIDTH-1:0] w_t;
    logic [DWIDTH:0]   w_sum, w_ya, w_yb;
    logic [DWIDTH-1:0] w_res_a, w_res_b;

    // Whole pipe moves together: only a held, unaccepted output blocks it.
    assign w_adv      = !r_out_valid || out_ready_i;
    assign in_ready_o = w_adv;

    // S2: Barrett quotient estimate
    assign w_prod = PW'(r_p1) * PW'(M);
    assign w_qh   = MW'(w_prod >> K);

    // S3: remainder is below 3Q, so two conditional subtracts fully reduce it
    assign w_r_full = r_p2 - K'(r_qh2) * c_q_p;
    assign w_r      = (DWIDTH+2)'(w_r_full);
    assign w_r1     = (w_r >= c_q_r) ? w_r - c_q_r : w_r;
    assign w_t_full = (w_r1 >= c_q_r) ? w_r1 - c_q_r : w_r1;
    assign w_t      = DWIDTH'(w_t_full);

    // S4: modular add / subtract
    assign w_sum = {1'b0, r_a3} + {1'b0, r_t3};
    assign w_ya  = (w_sum >= c_q_s) ? w_sum - c_q_s : w_sum;
    assign w_yb  = (r_a3 < r_t3) ? {1'b0, r_a3} - {1'b0, r_t3} + c_q_s
                                 : {1'b0, r_a3} - {1'b0, r_t3};

`ifdef BUTTERFLY_HALVE_EN
    logic [DWIDTH:0] w_ha, w_hb;
    // Halving mod odd Q: make the value even by adding Q before shifting.
    assign w_ha    = w_ya[0] ? (w_ya + c_q_s) >> 1 : w_ya >> 1;
    assign w_hb    = w_yb[0] ? (w_yb + c_q_s) >> 1 : w_yb >> 1;
    assign w_res_a = r_h3 ? DWIDTH'(w_ha) : DWIDTH'(w_ya);
    assign w_res_b = r_h3 ? DWIDTH'(w_hb) : DWIDTH'(w_yb);
`else
    assign w_res_a = DWIDTH'(w_ya);
    assign w_res_b = DWIDTH'(w_yb);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_a1        <= '0;
            r_a2        <= '0;
            r_a3        <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_qh2       <= '0;
            r_t3        <= '0;
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
`ifdef BUTTERFLY_HALVE_EN
            r_h1        <= 1'b0;
            r_h2        <= 1'b0;
            r_h3        <= 1'b0;
`endif
        end else if (w_adv) begin
            r_v1        <= in_valid_i;
            r_a1        <= a_i;
            r_p1        <= K'(b_i) * K'(w_i);
            r_v2        <= r_v1;
            r_a2        <= r_a1;
            r_p2        <= r_p1;
            r_qh2       <= w_qh;
            r_v3        <= r_v2;
            r_a3        <= r_a2;
            r_t3        <= w_t;
            r_out_valid <= r_v3;
            r_out_a     <= w_res_a;
            r_out_b     <= w_res_b;
`ifdef BUTTERFLY_HALVE_EN
            r_h1        <= half_i;
            r_h2        <= r_h1;
            r_h3        <= r_h2;
`endif
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_a_o     = r_out_a;
    assign out_b_o     = r_out_b;

endmodule
`default_nettype wire

// File: tb/tb_ct_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_butterfly_pipe
// Description : Scoreboard bench for ct_butterfly_pipe with a modular-arithmetic
//               reference model. Honours BUTTERFLY_HALVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_butterfly_pipe;

    localparam int DW = 12;
    localparam int QQ = 3329;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a, b, w;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_a, out_b;
`ifdef BUTTERFLY_HALVE_EN
    logic          half;
`endif

    ct_butterfly_pipe #(.DWIDTH(DW), .Q(QQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .w_i         (w),
`ifdef BUTTERFLY_HALVE_EN
        .half_i      (half),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_a_o     (out_a),
        .out_b_o     (out_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ea;
        int eb;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   rand_ready = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain modular arithmetic, halving as multiplication by 2^-1 mod Q.
    function automatic void model(input int ai, input int bi, input int wi, input bit h,
                                  output int ea, output int eb);
        int bw;
        bw = (bi * wi) % QQ;
        ea = (ai + bw) % QQ;
        eb = (ai - bw + QQ) % QQ;
        if (h) begin
            ea = (ea * ((QQ + 1) / 2)) % QQ;
            eb = (eb * ((QQ + 1) / 2)) % QQ;
        end
    endfunction

    // Monitor: pops and compares on every output handshake.
    exp_t mon_e;
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got a=%0d b=%0d, required no output", out_a, out_b);
            end else begin
                mon_e = sb.pop_front();
                check("out_a", int'(out_a), mon_e.ea);
                check("out_b", int'(out_b), mon_e.eb);
            end
            pop_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input int ai, input int bi, input int wi, input bit h,
                        input int ea, input int eb);
        exp_t e;
        bit   done = 1'b0;
        in_valid = 1'b1;
        a = DW'(ai);
        b = DW'(bi);
        w = DW'(wi);
`ifdef BUTTERFLY_HALVE_EN
        half = h;
`endif
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.ea = ea;
                e.eb = eb;
                sb.push_back(e);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic send_model(input int ai, input int bi, input int wi, input bit h);
        int ea, eb;
        model(ai, bi, wi, h, ea, eb);
        send(ai, bi, wi, h, ea, eb);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        check("drain_empty", sb.size(), 0);
    endtask

    int sa[6], sbv[6], sw[6];
    int held_a, held_b, n0;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        w = '0;
`ifdef BUTTERFLY_HALVE_EN
        half = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_a", int'(out_a), 0);
        check("rst_out_b", int'(out_b), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Latency: valid appears on the 4th negedge after acceptance.
        send(1, 1, 1, 1'b0, 2, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("latency_n%0d", k), int'(out_valid), (k == 4) ? 1 : 0);
        end
        tick();

        send(0, 3328, 3328, 1'b0, 1, 3328);
        send(3328, 1, 1, 1'b0, 0, 3327);
        send(5, 7, 0, 1'b0, 5, 5);
        send(100, 1, 3229, 1'b0, 0, 200);
        send(77, 1, 77, 1'b0, 154, 0);
`ifdef BUTTERFLY_HALVE_EN
        send(1, 0, 0, 1'b1, 1665, 1665);
        send(4, 1, 2, 1'b1, 3, 1);
`endif
        drain();

        // Backpressure: fill with out_ready low, check hold, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sa[i]  = $urandom_range(0, QQ - 1);
            sbv[i] = $urandom_range(0, QQ - 1);
            sw[i]  = $urandom_range(0, QQ - 1);
        end
        for (int i = 0; i < 4; i++) send_model(sa[i], sbv[i], sw[i], 1'b0);
        in_valid = 1'b1;
        a = DW'(sa[4]);
        b = DW'(sbv[4]);
        w = DW'(sw[4]);
        @(negedge clk);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_in_ready", int'(in_ready), 0);
        held_a = int'(out_a);
        held_b = int'(out_b);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("stall_in_ready_hold", int'(in_ready), 0);
            check("stall_hold_a", int'(out_a), held_a);
            check("stall_hold_b", int'(out_b), held_b);
        end
        tick();
        out_ready = 1'b1;
        n0 = pop_cyc.size();
        send_model(sa[4], sbv[4], sw[4], 1'b0);
        send_model(sa[5], sbv[5], sw[5], 1'b0);
        repeat (8) tick();
        check("stall_drain_count", pop_cyc.size() - n0, 6);
        if (pop_cyc.size() - n0 >= 6)
            check("stall_drain_back_to_back", pop_cyc[n0 + 5] - pop_cyc[n0], 5);
        drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) send_model(sa[i], sbv[i], sw[i], 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", int'(out_valid), 0);
            if (i == 0) begin
                check("post_rst_out_a", int'(out_a), 0);
                check("post_rst_out_b", int'(out_b), 0);
            end
        end
        tick();
        send_model(12, 34, 56, 1'b0);
        drain();

        // Randomized traffic with random backpressure and gaps.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) tick();
            send_model($urandom_range(0, QQ - 1), $urandom_range(0, QQ - 1),
                       $urandom_range(0, QQ - 1),
`ifdef BUTTERFLY_HALVE_EN
                       1'($urandom_range(0, 1))
`else
                       1'b0
`endif
                       );
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
